// File: rtl/shift_issue_pipe_pkg.sv
// Shared definitions for the shift issue pipeline.
//   shiftOp_e    : operation encodings carried on in_op
//   DATA_W       : operand/result width
//   SHAMT_W      : shift amount width
//   TAG_W        : opaque tag width
//   bufEntry_t   : one result-buffer entry (result, tag, zero, neg)
package shift_issue_pipe_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;
    localparam int TAG_W   = 4;

    typedef enum logic [1:0] {
        OP_SLL = 2'd0,
        OP_SRL = 2'd1,
        OP_SRA = 2'd2,
        OP_ROR = 2'd3
    } shiftOp_e;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [TAG_W-1:0]  tag;
        logic              zero;
        logic              neg;
    } bufEntry_t;

endpackage

// File: rtl/shift_issue_pipe_if.sv
// Handshake bus of the shift issue pipeline.
//   master : upstream/downstream agent (drives in_*, out_ready, flush)
//   slave  : the pipeline (drives in_ready, out_*, pending)
interface shift_issue_pipe_if;
    import shift_issue_pipe_pkg::*;

    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_operand;
    logic [SHAMT_W-1:0] in_shamt;
    logic [1:0]         in_op;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_result;
    logic [TAG_W-1:0]   out_tag;
    logic               out_zero;
    logic               out_neg;
    logic [2:0]         pending;

    modport master (
        output flush, in_valid, in_operand, in_shamt, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, out_zero, out_neg, pending
    );

    modport slave (
        input  flush, in_valid, in_operand, in_shamt, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, out_zero, out_neg, pending
    );

endinterface

// File: rtl/shift_issue_pipe_barrel_shift_unit.sv
// Combinational 5-layer logarithmic shifter.
//   operand : value to shift
//   shamt   : shift amount 0..31, bit k enables the 2**k layer
//   op      : SLL / SRL / SRA / ROR
//   result  : shifted value (shamt 0 passes operand through)
module barrel_shift_unit
    import shift_issue_pipe_pkg::*;
(
    input  logic [DATA_W-1:0]  operand,
    input  logic [SHAMT_W-1:0] shamt,
    input  shiftOp_e           op,
    output logic [DATA_W-1:0]  result
);

    // One fixed-distance layer; composing layers 1/2/4/8/16 gives any amount
    // because each op is closed under composition (SRA keeps the sign bit).
    function automatic logic [DATA_W-1:0] layerShift(
        input logic [DATA_W-1:0] x,
        input shiftOp_e          sop,
        input int                sh
    );
        logic signed [DATA_W-1:0] sx;
        sx = x;
        case (sop)
            OP_SLL:  layerShift = x << sh;
            OP_SRL:  layerShift = x >> sh;
            OP_SRA:  layerShift = sx >>> sh;
            default: layerShift = (x >> sh) | (x << (DATA_W - sh));
        endcase
    endfunction

    logic [DATA_W-1:0] l1, l2, l4, l8, l16;

    assign l1     = shamt[0] ? layerShift(operand, op, 1)  : operand;
    assign l2     = shamt[1] ? layerShift(l1,      op, 2)  : l1;
    assign l4     = shamt[2] ? layerShift(l2,      op, 4)  : l2;
    assign l8     = shamt[3] ? layerShift(l4,      op, 8)  : l4;
    assign l16    = shamt[4] ? layerShift(l8,      op, 16) : l8;
    assign result = l16;

endmodule

// File: rtl/shift_issue_pipe.sv
// Shift issue pipeline: single-entry issue register S1 feeding a DEPTH-entry
// FIFO result buffer. The shift is evaluated from S1 and captured on move.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of shift_issue_pipe_if (flush, in_* handshake,
//             out_* handshake, pending occupancy)
module shift_issue_pipe
    import shift_issue_pipe_pkg::*;
#(
    parameter int DEPTH = 2
)(
    input  logic              clock,
    input  logic              reset_n,
    shift_issue_pipe_if.slave bus
);

    localparam int         PTR_W   = (DEPTH > 2) ? 2 : 1;
    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        nextPtr = (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic                s1Vld_p1;
    logic [DATA_W-1:0]   s1Operand_p1;
    logic [SHAMT_W-1:0]  s1Shamt_p1;
    shiftOp_e            s1Op_p1;
    logic [TAG_W-1:0]    s1Tag_p1;

    bufEntry_t           bufMem_p2 [DEPTH];
    logic [PTR_W-1:0]    wrPtr, rdPtr;
    logic [2:0]          bufCount;

    logic [DATA_W-1:0]   shiftResult;
    bufEntry_t           newEntry;
    bufEntry_t           headEntry;
    logic                inReady, accept, s1Move, outValid, pop;

    // The move decision deliberately ignores a same-cycle pop so that
    // in_ready never depends on out_ready.
    assign s1Move   = s1Vld_p1 && (bufCount < DEPTH_C);
    assign inReady  = reset_n && !bus.flush && (!s1Vld_p1 || (bufCount < DEPTH_C));
    assign accept   = bus.in_valid && inReady;
    assign outValid = (bufCount != 3'd0);
    assign pop      = outValid && bus.out_ready;

    // ---- stage p1 -> p2 boundary: shift from S1 into a buffer entry ----
    barrel_shift_unit uShift (
        .operand (s1Operand_p1),
        .shamt   (s1Shamt_p1),
        .op      (s1Op_p1),
        .result  (shiftResult)
    );

    assign newEntry = '{result: shiftResult,
                        tag:    s1Tag_p1,
                        zero:   (shiftResult == '0),
                        neg:    shiftResult[DATA_W-1]};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1Vld_p1 <= 1'b0;
            bufCount <= 3'd0;
            wrPtr    <= '0;
            rdPtr    <= '0;
        end else if (bus.flush) begin
            s1Vld_p1 <= 1'b0;
            bufCount <= 3'd0;
            wrPtr    <= '0;
            rdPtr    <= '0;
        end else begin
            s1Vld_p1 <= accept || (s1Vld_p1 && !s1Move);
            bufCount <= bufCount + {2'b00, s1Move} - {2'b00, pop};
            if (s1Move) wrPtr <= nextPtr(wrPtr);
            if (pop)    rdPtr <= nextPtr(rdPtr);
        end
    end

    // ---- stage p0 -> p1 boundary: capture the accepted operation ----
    always_ff @(posedge clock) begin
        if (accept) begin
            s1Operand_p1 <= bus.in_operand;
            s1Shamt_p1   <= bus.in_shamt;
            s1Op_p1      <= shiftOp_e'(bus.in_op);
            s1Tag_p1     <= bus.in_tag;
        end
        if (s1Move) bufMem_p2[wrPtr] <= newEntry;
    end

    // Outputs are gated by outValid so reset/flush show zeros without
    // having to clear the buffer storage itself.
    assign headEntry      = bufMem_p2[rdPtr];
    assign bus.in_ready   = inReady;
    assign bus.out_valid  = outValid;
    assign bus.out_result = outValid ? headEntry.result : '0;
    assign bus.out_tag    = outValid ? headEntry.tag    : '0;
    assign bus.out_zero   = outValid && headEntry.zero;
    assign bus.out_neg    = outValid && headEntry.neg;
    assign bus.pending    = {2'b00, s1Vld_p1} + bufCount;

endmodule

// File: tb/tb_shift_issue_pipe.sv
// Directed self-checking bench for shift_issue_pipe (DEPTH = 2).
module tb_shift_issue_pipe;
    import shift_issue_pipe_pkg::*;

    localparam logic [1:0] SLL = 2'd0;
    localparam logic [1:0] SRL = 2'd1;
    localparam logic [1:0] SRA = 2'd2;
    localparam logic [1:0] ROR = 2'd3;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   nAsserts = 0;
    int   nFails   = 0;

    always #5 clock = ~clock;

    shift_issue_pipe_if bus();

    shift_issue_pipe #(.DEPTH(2)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [1:0] op, input logic [31:0] operand,
                         input logic [4:0] shamt, input logic [3:0] tag);
        bus.in_valid   = 1'b1;
        bus.in_op      = op;
        bus.in_operand = operand;
        bus.in_shamt   = shamt;
        bus.in_tag     = tag;
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic runOne(input string name, input logic [1:0] op, input logic [31:0] operand,
                          input logic [4:0] shamt, input logic [3:0] tag, input logic [31:0] exp);
        bus.out_ready = 1'b1;
        offer(op, operand, shamt, tag);
        step();
        bus.in_valid = 1'b0;
        chk({name, "_pend1"}, {29'd0, bus.pending}, 32'd1);
        chk({name, "_vld0"},  {31'd0, bus.out_valid}, 32'd0);
        step();
        chk({name, "_vld1"},  {31'd0, bus.out_valid}, 32'd1);
        chk({name, "_res"},   bus.out_result, exp);
        chk({name, "_tag"},   {28'd0, bus.out_tag}, {28'd0, tag});
        chk({name, "_zero"},  {31'd0, bus.out_zero}, {31'd0, exp == 32'd0});
        chk({name, "_neg"},   {31'd0, bus.out_neg}, {31'd0, exp[31]});
        step();
        chk({name, "_drain"}, {31'd0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.in_operand = '0; bus.in_shamt = '0; bus.in_op = '0; bus.in_tag = '0;

        // reset state
        #12;
        chk("rst_ready",  {31'd0, bus.in_ready}, 32'd0);
        chk("rst_vld",    {31'd0, bus.out_valid}, 32'd0);
        chk("rst_pend",   {29'd0, bus.pending}, 32'd0);
        chk("rst_res",    bus.out_result, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("post_rst_ready", {31'd0, bus.in_ready}, 32'd1);

        // SRA with hold under backpressure
        bus.out_ready = 1'b0;
        offer(SRA, 32'h8000_0000, 5'd4, 4'd3);
        step();
        bus.in_valid = 1'b0;
        chk("sra_pend1", {29'd0, bus.pending}, 32'd1);
        chk("sra_vld0",  {31'd0, bus.out_valid}, 32'd0);
        step();
        chk("sra_vld1",  {31'd0, bus.out_valid}, 32'd1);
        chk("sra_res",   bus.out_result, 32'hF800_0000);
        chk("sra_neg",   {31'd0, bus.out_neg}, 32'd1);
        chk("sra_tag",   {28'd0, bus.out_tag}, 32'd3);
        step();
        chk("sra_hold_res", bus.out_result, 32'hF800_0000);
        chk("sra_hold_tag", {28'd0, bus.out_tag}, 32'd3);
        bus.out_ready = 1'b1;
        step();
        chk("sra_pop_vld",  {31'd0, bus.out_valid}, 32'd0);
        chk("sra_pop_pend", {29'd0, bus.pending}, 32'd0);

        // shift vectors
        runOne("srl4",   SRL, 32'h8000_0000, 5'd4,  4'd1, 32'h0800_0000);
        runOne("sll31",  SLL, 32'h0000_0001, 5'd31, 4'd2, 32'h8000_0000);
        runOne("ror1",   ROR, 32'h0000_0001, 5'd1,  4'd4, 32'h8000_0000);
        runOne("sll0",   SLL, 32'h0000_0001, 5'd0,  4'd5, 32'h0000_0001);
        runOne("sllz",   SLL, 32'h8000_0000, 5'd1,  4'd6, 32'h0000_0000);
        runOne("sra0",   SRA, 32'h8000_0000, 5'd0,  4'd7, 32'h8000_0000);
        runOne("srapos", SRA, 32'h7FFF_FFF0, 5'd4,  4'd8, 32'h07FF_FFFF);
        runOne("ror8",   ROR, 32'h1234_5678, 5'd8,  4'd9, 32'h7812_3456);
        runOne("ror31",  ROR, 32'h0000_0001, 5'd31, 4'hA, 32'h0000_0002);
        runOne("srl31",  SRL, 32'hFFFF_FFFF, 5'd31, 4'hB, 32'h0000_0001);

        // backpressure: fill S1 + 2 buffer entries, then drain in order
        bus.out_ready = 1'b0;
        offer(SLL, 32'd1, 5'd0, 4'd1);
        step();
        offer(SLL, 32'd2, 5'd0, 4'd2);
        step();
        chk("bp_ready3", {31'd0, bus.in_ready}, 32'd1);
        offer(SLL, 32'd3, 5'd0, 4'd3);
        step();
        bus.in_valid = 1'b0;
        chk("bp_pend3",  {29'd0, bus.pending}, 32'd3);
        chk("bp_full",   {31'd0, bus.in_ready}, 32'd0);
        chk("bp_head1",  {28'd0, bus.out_tag}, 32'd1);
        bus.out_ready = 1'b1;
        step();
        chk("bp_head2",  {28'd0, bus.out_tag}, 32'd2);
        chk("bp_res2",   bus.out_result, 32'd2);
        chk("bp_pend2",  {29'd0, bus.pending}, 32'd2);
        step();
        chk("bp_head3",  {28'd0, bus.out_tag}, 32'd3);
        chk("bp_vld3",   {31'd0, bus.out_valid}, 32'd1);
        chk("bp_pend1",  {29'd0, bus.pending}, 32'd1);
        step();
        chk("bp_empty",  {31'd0, bus.out_valid}, 32'd0);

        // streaming: 16 ops back to back, one result per cycle
        bus.out_ready = 1'b1;
        for (int c = 0; c < 18; c++) begin
            if (c >= 2) begin
                chk("strm_vld", {31'd0, bus.out_valid}, 32'd1);
                chk("strm_tag", {28'd0, bus.out_tag}, 32'(c - 2));
                chk("strm_res", bus.out_result, 32'd1 << (c - 2));
            end
            if (c < 16) begin
                chk("strm_ready", {31'd0, bus.in_ready}, 32'd1);
                offer(SLL, 32'd1, 5'(c), 4'(c));
            end else begin
                bus.in_valid = 1'b0;
            end
            step();
        end
        chk("strm_end", {31'd0, bus.out_valid}, 32'd0);

        // flush with pending = 3 and an op offered
        bus.out_ready = 1'b0;
        offer(SLL, 32'd1, 5'd0, 4'd1);
        step();
        offer(SLL, 32'd2, 5'd0, 4'd2);
        step();
        offer(SLL, 32'd3, 5'd0, 4'd3);
        step();
        chk("fl_pend3", {29'd0, bus.pending}, 32'd3);
        bus.flush = 1'b1;
        offer(SLL, 32'd9, 5'd0, 4'd9);
        step();
        chk("fl_pend0", {29'd0, bus.pending}, 32'd0);
        chk("fl_vld0",  {31'd0, bus.out_valid}, 32'd0);
        chk("fl_res0",  bus.out_result, 32'd0);
        chk("fl_block", {31'd0, bus.in_ready}, 32'd0);
        step();
        chk("fl_noacc", {29'd0, bus.pending}, 32'd0);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("fl_ready", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clock);

        // asynchronous reset mid-stream
        bus.out_ready = 1'b0;
        offer(SRL, 32'hF000_0000, 5'd4, 4'd5);
        step();
        offer(SRL, 32'hF000_0000, 5'd8, 4'd6);
        step();
        bus.in_valid = 1'b0;
        chk("mr_pend2", {29'd0, bus.pending}, 32'd2);
        chk("mr_vld",   {31'd0, bus.out_valid}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mr_pend0",  {29'd0, bus.pending}, 32'd0);
        chk("mr_vld0",   {31'd0, bus.out_valid}, 32'd0);
        chk("mr_res0",   bus.out_result, 32'd0);
        chk("mr_tag0",   {28'd0, bus.out_tag}, 32'd0);
        chk("mr_ready0", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        runOne("mr_first", SRL, 32'hF000_0000, 5'd28, 4'd7, 32'h0000_000F);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
